// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: one-hot FSM encodings,
// frame length and parity computation.
package uart_pkg;

  typedef enum logic [4:0] {
    TX_IDLE   = 5'b00001,
    TX_START  = 5'b00010,
    TX_DATA   = 5'b00100,
    TX_PARITY = 5'b01000,
    TX_STOP   = 5'b10000
  } tx_state_t;

  typedef enum logic [5:0] {
    RX_IDLE      = 6'b000001,
    RX_START     = 6'b000010,
    RX_DATA      = 6'b000100,
    RX_PARITY    = 6'b001000,
    RX_STOP      = 6'b010000,
    RX_WAIT_HIGH = 6'b100000
  } rx_state_t;

  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // XOR of the low data_bits bits, inverted for odd parity.
  function automatic logic parity_of(input logic [7:0] data, input int data_bits,
                                     input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used as the UART receive buffer. A push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; the count gates every read, so stale words
  // are never visible and the array can map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX serializer and RX deserializer with independent bit
// timers, configurable framing, receive FIFO and sticky error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV       = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx,
  input  logic                             rx,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
  output logic                             err_frame,
  output logic                             err_parity,
  output logic                             err_overrun,
  input  logic                             err_clear
);

  localparam int CNT_W      = $clog2(CLK_DIV);
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_ready   = (tx_state == TX_IDLE);

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx         = 1'b1;
    unique case (tx_state)
      TX_IDLE:   if (tx_valid) tx_state_n = TX_START;
      TX_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_bit_end && tx_idx == DATA_LAST)
          tx_state_n = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && tx_idx == STOP_LAST) tx_state_n = TX_IDLE;
      default:   tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (tx_valid) begin
          tx_shift <= tx_data[DATA_BITS-1:0];
          tx_par   <= parity_of(tx_data, DATA_BITS, ODD);
        end
      end else if (tx_bit_end) begin
        tx_cnt <= '0;
        tx_idx <= (tx_state_n != tx_state) ? '0 : tx_idx + 1'b1;
        if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_meta, rx_s;
  rx_state_t            rx_state, rx_state_n;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_end, rx_half_end;
  logic                 rx_push, set_frame, set_parity, set_overrun;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign rx_bit_end  = (rx_cnt == BIT_LAST);
  assign rx_half_end = (rx_cnt == HALF_LAST);

  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s) rx_state_n = RX_START;
      // Mid-start recheck rejects short low glitches.
      RX_START: if (rx_half_end) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_bit_end && rx_idx == DATA_LAST)
          rx_state_n = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:
        if (rx_bit_end) begin
          rx_state_n = RX_STOP;
          set_parity = (rx_s != parity_of(8'(rx_shift), DATA_BITS, ODD));
        end
      RX_STOP:
        if (rx_bit_end) begin
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            set_frame  = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end
        end
      RX_WAIT_HIGH: if (rx_s) rx_state_n = RX_IDLE;
      default:      rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_state_n != rx_state || rx_bit_end ||
          rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != RX_DATA)
        rx_idx <= '0;
      else if (rx_bit_end)
        rx_idx <= rx_idx + 1'b1;
      if (rx_state == RX_DATA && rx_bit_end)
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
    end
  end

  assign rx_valid    = ~fifo_empty;
  assign fifo_pop    = rx_valid & rx_ready;
  assign set_overrun = rx_push & fifo_full & ~fifo_pop;
  assign rx_data     = 8'(fifo_dout);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_shift),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (rx_level)
  );

  // Sticky flags: a set in the same cycle as err_clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= set_frame   | (err_frame   & ~err_clear);
      err_parity  <= set_parity  | (err_parity  & ~err_clear);
      err_overrun <= set_overrun | (err_overrun & ~err_clear);
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: a frame-level TX model and an RX byte
// queue checked every cycle, plus directed frames with literal expectations.
module tb_uart_core;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;
  localparam int FB    = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx;
  logic       rx_line, rx_drv, loop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] rx_level;
  logic       err_frame, err_parity, err_overrun, err_clear;

  logic [7:0] p_tx_data;
  logic       p_tx_valid, p_tx_ready, p_tx, p_rx;
  logic [7:0] p_rx_data;
  logic       p_rx_valid, p_rx_ready;
  logic [2:0] p_rx_level;
  logic       p_err_frame, p_err_parity, p_err_overrun, p_err_clear;

  always #5 clk = ~clk;
  assign rx_line = loop ? tx : rx_drv;

  uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
              .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .rx(rx_line), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
    .err_frame(err_frame), .err_parity(err_parity),
    .err_overrun(err_overrun), .err_clear(err_clear));

  uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
              .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH)) dut_p (
    .clk(clk), .rst(rst), .tx_data(p_tx_data), .tx_valid(p_tx_valid),
    .tx_ready(p_tx_ready), .tx(p_tx), .rx(p_rx), .rx_data(p_rx_data),
    .rx_valid(p_rx_valid), .rx_ready(p_rx_ready), .rx_level(p_rx_level),
    .err_frame(p_err_frame), .err_parity(p_err_parity),
    .err_overrun(p_err_overrun), .err_clear(p_err_clear));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          armed = 1'b0;
  int          rem = 0, el = 0;
  logic [11:0] frm = '1;
  logic [7:0]  exp_q[$];
  bit          m_frame = 1'b0, m_overrun = 1'b0;

  // Serial frame as a bit list: start, 8 data LSB first, one stop.
  function automatic logic [11:0] frame_of(input logic [7:0] b);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    return f;
  endfunction

  task automatic expect_byte(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_overrun = 1'b1;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("tx_line", tx, (rem == 0) ? 1'b1 : frm[el / DIV]);
      check("tx_ready", tx_ready, rem == 0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
        else check("rx_data_pop", rx_data, exp_q.pop_front());
      end
      if (rst) begin
        rem = 0;
      end else if (rem == 0) begin
        if (tx_valid) begin
          frm = frame_of(tx_data);
          rem = FB * DIV;
          el  = 0;
        end
      end else begin
        rem--;
        el++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("tx_accept", tx_ready, 1);
    @(posedge clk);
    #1;
    if (loop) expect_byte(b);
  endtask

  task automatic rx_bit(input bit to_p, input logic v);
    if (to_p) p_rx = v;
    else rx_drv = v;
    tick(DIV);
  endtask

  task automatic rx_frame(input bit to_p, input logic [7:0] b, input bit pe,
                          input logic pbit, input logic stop);
    rx_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) rx_bit(to_p, b[i]);
    if (pe) rx_bit(to_p, pbit);
    rx_bit(to_p, stop);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick(1);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_frame"}, err_frame, m_frame);
    check({tag, "_err_parity"}, err_parity, 0);
    check({tag, "_err_overrun"}, err_overrun, m_overrun);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    m_frame   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0] lit;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    rx_ready = 1'b0; err_clear = 1'b0;
    p_tx_data = '0; p_tx_valid = 1'b0; p_rx = 1'b1; p_rx_ready = 1'b0;
    p_err_clear = 1'b0;
    tick(3);

    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_level", rx_level, 0);
    check_errs("rst");
    check("rst_p_tx", p_tx, 1);
    rst   = 1'b0;
    armed = 1'b1;
    tick(2);

    // 8N1 0xA5: literal line levels at mid-bit and ready timing.
    lit = 10'b1101001010;
    send_tx(8'hA5);
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < FB; k++) begin
      if (k != 0) repeat (DIV) @(negedge clk);
      check("a5_bit_level", tx, lit[k]);
    end
    repeat (4) @(negedge clk);
    check("a5_ready_cycle80", tx_ready, 0);
    @(negedge clk);
    check("a5_ready_cycle81", tx_ready, 1);
    tick(1);

    // Loopback, back-to-back frames.
    loop     = 1'b1;
    rx_ready = 1'b1;
    send_tx(8'h00);
    send_tx(8'hFF);
    send_tx(8'h5A);
    tx_valid = 1'b0;
    drain("loop_drain");
    tick(2 * DIV);
    check("loop_rx_valid", rx_valid, 0);
    check_errs("loop");
    loop = 1'b0;

    // Even parity: 0x03 has even parity 0, so a driven 1 is a mismatch.
    rx_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("par_rx_valid", p_rx_valid, 1);
    check("par_rx_data", p_rx_data, 8'h03);
    check("par_err_parity", p_err_parity, 1);
    check("par_err_frame", p_err_frame, 0);
    p_err_clear = 1'b1;
    tick(1);
    p_err_clear = 1'b0;
    check("par_cleared", p_err_parity, 0);
    p_rx_ready = 1'b1;
    tick(1);
    p_rx_ready = 1'b0;
    check("par_popped", p_rx_valid, 0);
    rx_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("par_good_data", p_rx_data, 8'h07);
    check("par_good_noerr", p_err_parity, 0);

    // Start glitch of 3 cycles, then a normal frame to show RX is idle.
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(3 * DIV);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_rx_level", rx_level, 0);
    check_errs("glitch");
    expect_byte(8'h3C);
    rx_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drain("glitch_follow_drain");

    // Framing error, long break, then recovery.
    rx_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    m_frame = 1'b1;
    tick(50);
    check("frame_rx_valid", rx_valid, 0);
    check_errs("frame");
    rx_drv = 1'b1;
    tick(2 * DIV);
    expect_byte(8'h42);
    rx_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    drain("frame_recover_drain");
    check_errs("frame_after");
    clear_errs();
    check_errs("frame_cleared");

    // Overrun: five frames into a four-entry FIFO with no consumer.
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_byte(8'h10 + 8'(i));
      rx_frame(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
      check("ovr_rx_level", rx_level, exp_q.size());
      check("ovr_err_overrun", err_overrun, m_overrun);
    end
    tick(4);
    check("ovr_level_full", rx_level, 4);
    check("ovr_head", rx_data, 8'h10);
    rx_ready = 1'b1;
    drain("ovr_drain");
    tick(2);
    check("ovr_empty_level", rx_level, 0);
    rx_ready = 1'b0;
    clear_errs();
    check_errs("ovr_cleared");

    // Reset mid-frame: TX idles, FIFO empties.
    expect_byte(8'h33);
    rx_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    check("rstmid_level_before", rx_level, 1);
    send_tx(8'h55);
    tx_valid = 1'b0;
    tick(20);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    check("rstmid_tx", tx, 1);
    check("rstmid_tx_ready", tx_ready, 1);
    check("rstmid_rx_level", rx_level, 0);
    check("rstmid_rx_valid", rx_valid, 0);
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: a TX serializer and an RX deserializer, each with an independent bit-period counter.
- Data bits, parity and stop bits are configurable at elaboration time.
- RX has a 2-flop input synchroniser, start-bit glitch rejection and a small receive FIFO.
- Sticky error flags for framing, parity and overrun.
- Sits between the CPU peripheral bus decoder and the chip pins; replaces the fixed 8N1, single-byte, level-handshake UART.

Parameters:
- CLK_DIV, 434, clock cycles per bit (>= 4); 434 = 115200 baud at 50 MHz.
- DATA_BITS, 8, data bits per frame, 5..8.
- PARITY_EN, 0, 1 = append/check one parity bit after data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0).
- STOP_BITS, 1, 1 or 2 stop bits on TX; RX checks only the first.
- RX_FIFO_DEPTH, 4, receive FIFO entries, power of two >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- tx_data  in  8  byte to send; bits above DATA_BITS are ignored
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter idle, can accept a byte
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous
- rx_data  out  8  FIFO head, zero-extended above DATA_BITS
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops the head when rx_valid is high
- rx_level  out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy
- err_frame  out  1  sticky: stop bit sampled low
- err_parity  out  1  sticky: parity mismatch
- err_overrun  out  1  sticky: byte received while FIFO full
- err_clear  in  1  clears all sticky flags

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, rx_level = 0, all err_* = 0, both FSMs IDLE, synchroniser flops = 1.
- Frame layout: FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS. LSB first: start (0), data, parity, stop (1).
- Parity bit: XOR of the data bits, inverted when PARITY_ODD = 1.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - A byte is accepted on any edge where tx_valid & tx_ready; the byte is latched on that edge.
  - tx_ready falls the next cycle. tx drives the start bit from the next cycle.
  - Each bit is held exactly CLK_DIV cycles.
  - tx_ready is high again exactly FRAME_BITS*CLK_DIV cycles after the acceptance edge, so back-to-back frames have no idle gap.
  - PARITY is skipped when PARITY_EN = 0. STOP repeats STOP_BITS times.
  - tx_valid deassertion mid-frame has no effect.
- RX synchroniser: rx passes through 2 flops; all RX logic uses the synchronised value (rx_s). Latency is 2 cycles.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> (WAIT_HIGH) -> IDLE:
  - IDLE: rx_s == 0 enters START and clears the counter.
  - START: at count CLK_DIV/2 - 1, if rx_s == 1 it is a glitch and the FSM returns to IDLE with no flags; otherwise the counter restarts.
  - DATA, PARITY, STOP: sample rx_s each time the counter reaches CLK_DIV - 1, i.e. at mid-bit. Data shifts in LSB first.
  - PARITY: a mismatch sets err_parity. The byte is still pushed.
  - STOP = 1: push the byte to the FIFO and go to IDLE on the next cycle. The second stop bit is not checked; a new start can be detected during it.
  - STOP = 0: set err_frame, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1 (break handling), then go to IDLE.
- Push/pop timing:
  - A push is visible on rx_valid the cycle after the stop sample.
  - A pop occurs when rx_valid & rx_ready. rx_data is the head combinationally from FIFO storage.
- Full FIFO:
  - A push while full with no pop in the same cycle drops the new byte and sets err_overrun. FIFO contents are unchanged.
  - A push and pop in the same cycle while full: both happen; no overrun.
  - Empty FIFO: rx_ready is ignored.
  - Pointers wrap modulo RX_FIFO_DEPTH. rx_level counts 0..RX_FIFO_DEPTH.
- Sticky flags: err_clear clears all sticky flags. If a set event and err_clear occur in the same cycle, set wins.
- Reset mid-frame: tx returns high in the next cycle, the partial RX frame is discarded, and the FIFO is emptied.

Decomposition:
- Package uart_pkg:
  - RX and TX state encodings (one-hot localparams).
  - Function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS).
  - Function parity_of(data, DATA_BITS, odd).
- Sub-module uart_fifo: synchronous FIFO, parameters WIDTH and DEPTH. Ports push, pop, din, dout, full, empty, level. Instantiated once for RX.
- TX and RX FSMs stay in uart_core.

Test Plan:
1. CLK_DIV=8, 8N1, send 0xA5 -> tx levels 0,1,0,1,0,0,1,0,1,1, each 8 cycles; tx_ready high 80 cycles after acceptance.
2. Loopback tx->rx, bytes 0x00, 0xFF, 0x5A back-to-back -> rx_data pops 0x00, 0xFF, 0x5A in order; no err_* set.
3. PARITY_EN=1, PARITY_ODD=0, drive frame 0x03 with parity bit 1 -> byte 0x03 pushed, err_parity=1; err_clear -> 0.
4. rx low pulse of 3 cycles (CLK_DIV=8) -> no push, no flags, FSM back in IDLE.
5. Stop bit driven 0 on byte 0x41 -> no push, err_frame=1; rx held low 50 cycles then released -> next valid frame 0x42 received correctly.
6. RX_FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x10..0x14 -> rx_level=4, err_overrun=1; pops return 0x10..0x13.
